// File: rtl/game_cmd_sequencer_if.sv
// Signal bundle between game_cmd_sequencer, the raw player/collision inputs
// and gameFSM. The sequencer connects through the slave modport.
interface game_cmd_sequencer_if;
   logic       btn_start;
   logic       btn_pause;
   logic       btn_reset;
   logic       collision;
   logic [2:0] state;
   logic       startGame;
   logic       pauseGame;
   logic       reset;
   logic       dead;
   logic       busy;
   logic       drop;
   logic       timeout_err;

   modport master (
      output btn_start, btn_pause, btn_reset, collision, state,
      input  startGame, pauseGame, reset, dead, busy, drop, timeout_err
   );

   modport slave (
      input  btn_start, btn_pause, btn_reset, collision, state,
      output startGame, pauseGame, reset, dead, busy, drop, timeout_err
   );
endinterface

// File: rtl/game_cmd_sequencer.sv
// Debounces player buttons, arbitrates pending commands and issues legal ones to gameFSM.
// Optional macro PAUSE_TOGGLE_EN: a pause press while PAUSE resumes the game via startGame.
module game_cmd_sequencer #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int ACK_TIMEOUT     = 32
) (
   input logic                 clk,
   input logic                 resetFSM,
   game_cmd_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      GS_START    = 3'b000,
      GS_PLAYING  = 3'b001,
      GS_PAUSE    = 3'b010,
      GS_RESET    = 3'b011,
      GS_GAMEOVER = 3'b100
   } game_state_e;

   // Values double as bit positions in the pending and pulse vectors.
   typedef enum logic [1:0] {
      CMD_START = 2'd0,
      CMD_PAUSE = 2'd1,
      CMD_RESET = 2'd2,
      CMD_DEAD  = 2'd3
   } cmd_e;

   typedef enum logic [1:0] {
      SQ_IDLE,
      SQ_ISSUE,
      SQ_WAIT
   } seq_e;

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

   logic [2:0]    raw;
   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    deb;
   logic [2:0]    deb_q;
   logic [DW-1:0] db_cnt [3];

   logic [3:0]    pend;
   logic [3:0]    pend_set;
   logic [3:0]    pend_clr;
   logic [3:0]    top_hot;
   logic [3:0]    issue_hot;
   cmd_e          top;
   logic          top_vld;
   logic          legal;

   seq_e          sq;
   logic [2:0]    s0;
   logic [TW-1:0] to_cnt;
   logic [3:0]    pulse;
   logic          busy_r;
   logic          drop_r;
   logic          terr_r;

   assign raw = {bus.btn_reset, bus.btn_pause, bus.btn_start};

   always_ff @(posedge clk or negedge resetFSM) begin
      if (!resetFSM) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_q <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments let sync2 take the old sync1, forming a real two-flop chain.
         sync1 <= raw;
         sync2 <= sync1;
         deb_q <= deb;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb[i]    <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Rising debounced levels and collision feed the pending flags.
   assign pend_set = {bus.collision, deb & ~deb_q};

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      top       = CMD_START;
      top_vld   = |pend;
      legal     = 1'b0;
      top_hot   = '0;
      issue_hot = '0;
      if (pend[CMD_RESET])      top = CMD_RESET;
      else if (pend[CMD_DEAD])  top = CMD_DEAD;
      else if (pend[CMD_PAUSE]) top = CMD_PAUSE;
      case (top)
         CMD_RESET: legal = 1'b1;
         CMD_DEAD:  legal = (bus.state == GS_PLAYING);
`ifdef PAUSE_TOGGLE_EN
         CMD_PAUSE: legal = (bus.state == GS_PLAYING) || (bus.state == GS_PAUSE);
`else
         CMD_PAUSE: legal = (bus.state == GS_PLAYING);
`endif
         CMD_START: legal = (bus.state == GS_START) || (bus.state == GS_RESET) ||
                            (bus.state == GS_PAUSE);
      endcase
      top_hot[top]   = 1'b1;
      issue_hot[top] = 1'b1;
`ifdef PAUSE_TOGGLE_EN
      if (top == CMD_PAUSE && bus.state == GS_PAUSE) begin
         issue_hot            = '0;
         issue_hot[CMD_START] = 1'b1;
      end
`endif
      pend_clr = (sq == SQ_IDLE && top_vld) ? top_hot : 4'b0000;
   end

   always_ff @(posedge clk or negedge resetFSM) begin
      if (!resetFSM) begin
         sq     <= SQ_IDLE;
         pend   <= '0;
         s0     <= '0;
         to_cnt <= '0;
         pulse  <= '0;
         busy_r <= 1'b0;
         drop_r <= 1'b0;
         terr_r <= 1'b0;
      end else begin
         pulse  <= '0;
         drop_r <= 1'b0;
         // A new event on the same edge as the clear is kept, not lost.
         pend   <= (pend & ~pend_clr) | pend_set;
         case (sq)
            SQ_IDLE: begin
               if (top_vld) begin
                  s0 <= bus.state;
                  if (legal) begin
                     pulse  <= issue_hot;
                     busy_r <= 1'b1;
                     sq     <= SQ_ISSUE;
                  end else begin
                     drop_r <= 1'b1;
                  end
               end
            end
            SQ_ISSUE: begin
               to_cnt <= '0;
               sq     <= SQ_WAIT;
            end
            SQ_WAIT: begin
               if (bus.state != s0) begin
                  busy_r <= 1'b0;
                  sq     <= SQ_IDLE;
               end else if (to_cnt == TO_LAST) begin
                  terr_r <= 1'b1;
                  busy_r <= 1'b0;
                  sq     <= SQ_IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: begin
               busy_r <= 1'b0;
               sq     <= SQ_IDLE;
            end
         endcase
      end
   end

   assign bus.startGame   = pulse[CMD_START];
   assign bus.pauseGame   = pulse[CMD_PAUSE];
   assign bus.reset       = pulse[CMD_RESET];
   assign bus.dead        = pulse[CMD_DEAD];
   assign bus.busy        = busy_r;
   assign bus.drop        = drop_r;
   assign bus.timeout_err = terr_r;

endmodule

// File: tb/tb_game_cmd_sequencer.sv
// Self-checking bench for game_cmd_sequencer: an event-level reference model compared
// every cycle, plus directed scenarios with hand-computed edge numbers.
module tb_game_cmd_sequencer;
   localparam int N = 4;
   localparam int T = 8;
`ifdef PAUSE_TOGGLE_EN
   localparam bit TOGGLE = 1'b1;
`else
   localparam bit TOGGLE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   game_cmd_sequencer_if bus ();

   game_cmd_sequencer #(.DEBOUNCE_CYCLES(N), .ACK_TIMEOUT(T)) dut (
      .clk      (clk),
      .resetFSM (rst_n),
      .bus      (bus)
   );

   initial forever #5 clk = ~clk;

   int         n_checks = 0;
   int         n_pass   = 0;
   int         edge_no  = 0;
   bit         chk_en   = 1'b0;
   bit         ack_en   = 1'b1;
   int         ev [7][$];
   logic [6:0] outs;

   // Bit order: start, pause, reset, dead, busy, drop, timeout_err.
   assign outs = {bus.timeout_err, bus.drop, bus.busy, bus.dead, bus.reset,
                  bus.pauseGame, bus.startGame};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: raw delay line, debounce by stable-run history, pending set,
   // and the command sequencing rules expressed as events per clock edge.
   bit         m_deb  [3];
   bit         m_rose [3];
   bit         m_dly  [3][$];
   bit         m_hist [3][$];
   bit         m_pend [4];
   int         m_mode;
   int         m_wait;
   logic [2:0] m_s0;
   logic [6:0] m_out;

   function automatic bit legal_cmd(int c, logic [2:0] s);
      case (c)
         2:       return 1'b1;
         3:       return s == 3'b001;
         1:       return (s == 3'b001) || (TOGGLE && s == 3'b010);
         default: return (s == 3'b000) || (s == 3'b010) || (s == 3'b011);
      endcase
   endfunction

   function automatic int out_bit(int c, logic [2:0] s);
      if (c == 1 && s == 3'b010) return 0;
      return c;
   endfunction

   task automatic m_reset();
      for (int b = 0; b < 3; b++) begin
         m_deb[b]  = 1'b0;
         m_rose[b] = 1'b0;
         m_dly[b].delete();
         m_dly[b].push_back(1'b0);
         m_dly[b].push_back(1'b0);
         m_hist[b].delete();
      end
      for (int c = 0; c < 4; c++) m_pend[c] = 1'b0;
      m_mode = 0;
      m_wait = 0;
      m_s0   = '0;
      m_out  = '0;
   endtask

   task automatic m_step();
      logic [6:0] nxt;
      bit         clr [4];
      bit         raw [3];
      bit         used;
      bit         all_diff;
      int         top;
      raw[0] = bus.btn_start;
      raw[1] = bus.btn_pause;
      raw[2] = bus.btn_reset;
      for (int c = 0; c < 4; c++) clr[c] = 1'b0;
      nxt = m_out & 7'b1010000;
      top = -1;
      if (m_mode == 0) begin
         if (m_pend[2]) top = 2;
         else if (m_pend[3]) top = 3;
         else if (m_pend[1]) top = 1;
         else if (m_pend[0]) top = 0;
         if (top >= 0) begin
            clr[top] = 1'b1;
            m_s0     = bus.state;
            if (legal_cmd(top, bus.state)) begin
               nxt[out_bit(top, bus.state)] = 1'b1;
               nxt[4] = 1'b1;
               m_mode = 1;
            end else begin
               nxt[5] = 1'b1;
            end
         end
      end else if (m_mode == 1) begin
         m_mode = 2;
         m_wait = 0;
      end else if (bus.state != m_s0) begin
         m_mode = 0;
         nxt[4] = 1'b0;
      end else begin
         m_wait++;
         if (m_wait == T) begin
            nxt[6] = 1'b1;
            nxt[4] = 1'b0;
            m_mode = 0;
         end
      end
      for (int b = 0; b < 3; b++) m_pend[b] = (m_pend[b] && !clr[b]) || m_rose[b];
      m_pend[3] = (m_pend[3] && !clr[3]) || (bus.collision === 1'b1);
      for (int b = 0; b < 3; b++) begin
         used = m_dly[b].pop_front();
         m_dly[b].push_back(raw[b]);
         m_rose[b] = 1'b0;
         m_hist[b].push_back(used);
         if (m_hist[b].size() > N) void'(m_hist[b].pop_front());
         all_diff = (m_hist[b].size() == N);
         for (int k = 0; k < m_hist[b].size(); k++)
            if (m_hist[b][k] == m_deb[b]) all_diff = 1'b0;
         if (all_diff) begin
            m_deb[b]  = !m_deb[b];
            m_hist[b].delete();
            m_rose[b] = m_deb[b];
         end
      end
      m_out = nxt;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else m_step();
      end
   end

   initial forever begin
      @(posedge clk);
      edge_no++;
   end

   // Per-cycle comparison against the model, plus an event log of output edges.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("cycle_outputs", outs, m_out);
         for (int i = 0; i < 7; i++) if (outs[i] === 1'b1) ev[i].push_back(edge_no);
      end
   end

   function automatic int ev_at(int i, int k);
      if (k < ev[i].size()) return ev[i][k];
      return -1;
   endfunction

   task automatic clear_ev();
      for (int i = 0; i < 7; i++) ev[i].delete();
   endtask

   // Stand-in for gameFSM: moves state in response to command pulses.
   task automatic respond();
      if (ack_en) begin
         if (bus.startGame === 1'b1)      bus.state = 3'b001;
         else if (bus.pauseGame === 1'b1) bus.state = 3'b010;
         else if (bus.reset === 1'b1)     bus.state = 3'b011;
         else if (bus.dead === 1'b1)      bus.state = 3'b100;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         respond();
      end
   endtask

   int p;

   initial begin
      rst_n         = 1'b1;
      bus.btn_start = 1'b0;
      bus.btn_pause = 1'b0;
      bus.btn_reset = 1'b0;
      bus.collision = 1'b0;
      bus.state     = 3'b011;
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;

      // 1: reset values, then a clean start press in RESET
      tick(2);
      check("t1_reset_outputs", outs, 0);
      #2 rst_n = 1'b1;
      tick(1);
      clear_ev();
      p = edge_no;
      bus.btn_start = 1'b1;
      tick(14);
      check("t1_start_count", ev[0].size(), 1);
      check("t1_start_edge", ev_at(0, 0), p + 8);
      check("t1_busy_first", ev_at(4, 0), p + 8);
      check("t1_busy_count", ev[4].size(), 2);
      bus.btn_start = 1'b0;
      tick(10);

      // 2: bouncing pause is rejected, a steady press issues once
      bus.state = 3'b001;
      clear_ev();
      for (int i = 0; i < 20; i++) begin
         bus.btn_pause = ((i / 2) % 2 == 0);
         tick(1);
      end
      check("t2_bounce_pause", ev[1].size(), 0);
      check("t2_bounce_drop", ev[5].size(), 0);
      p = edge_no;
      bus.btn_pause = 1'b1;
      tick(10);
      bus.btn_pause = 1'b0;
      tick(10);
      check("t2_pause_count", ev[1].size(), 1);
      check("t2_pause_edge", ev_at(1, 0), p + 8);
      check("t2_drop_count", ev[5].size(), 0);

      // 3: reset, dead and pause pending together
      bus.state = 3'b001;
      clear_ev();
      p = edge_no;
      bus.btn_pause = 1'b1;
      bus.btn_reset = 1'b1;
      tick(6);
      bus.collision = 1'b1;
      tick(1);
      bus.collision = 1'b0;
      tick(12);
      check("t3_reset_count", ev[2].size(), 1);
      check("t3_reset_edge", ev_at(2, 0), p + 8);
      check("t3_drop_count", ev[5].size(), 2);
      check("t3_drop_dead_edge", ev_at(5, 0), p + 11);
      check("t3_drop_pause_edge", ev_at(5, 1), p + 12);
      check("t3_no_dead_or_pause", ev[3].size() + ev[1].size(), 0);
      bus.btn_pause = 1'b0;
      bus.btn_reset = 1'b0;
      tick(10);

      // 4: pause in GAMEOVER is illegal
      bus.state = 3'b100;
      clear_ev();
      p = edge_no;
      bus.btn_pause = 1'b1;
      tick(10);
      bus.btn_pause = 1'b0;
      tick(8);
      check("t4_drop_edge", ev_at(5, 0), p + 8);
      check("t4_drop_count", ev[5].size(), 1);
      check("t4_no_pause", ev[1].size(), 0);
      check("t4_no_busy", ev[4].size(), 0);

      // 5: gameFSM never acknowledges, so WAIT times out
      ack_en    = 1'b0;
      bus.state = 3'b001;
      clear_ev();
      p = edge_no;
      bus.btn_pause = 1'b1;
      tick(10);
      bus.btn_pause = 1'b0;
      tick(15);
      check("t5_pause_edge", ev_at(1, 0), p + 8);
      check("t5_busy_first", ev_at(4, 0), p + 8);
      check("t5_busy_count", ev[4].size(), 9);
      check("t5_terr_first", ev_at(6, 0), p + 17);
      check("t5_terr_held", outs[6], 1);
      #2 rst_n = 1'b0;
      tick(2);
      check("t5_terr_cleared", outs[6], 0);
      check("t5_outputs_in_reset", outs, 0);
      #2 rst_n = 1'b1;
      ack_en = 1'b1;
      tick(1);

      // 6: pause pressed while PAUSE
      bus.state = 3'b010;
      clear_ev();
      p = edge_no;
      bus.btn_pause = 1'b1;
      tick(10);
      bus.btn_pause = 1'b0;
      tick(10);
      check("t6_no_pause_pulse", ev[1].size(), 0);
`ifdef PAUSE_TOGGLE_EN
      check("t6_resume_edge", ev_at(0, 0), p + 8);
      check("t6_no_drop", ev[5].size(), 0);
`else
      check("t6_drop_edge", ev_at(5, 0), p + 8);
      check("t6_no_start", ev[0].size(), 0);
`endif

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/game_cmd_sequencer.md
Name: game_cmd_sequencer

Overview:
- Sits between the console's raw player buttons and collision logic on one side, and `gameFSM` on the other.
- Synchronises and debounces the buttons, then edge-detects them into pending commands.
- Arbitrates simultaneous commands by fixed priority and filters out commands that are illegal in the current game state.
- Issues each legal command to `gameFSM` as a one-cycle pulse on `startGame` / `pauseGame` / `reset` / `dead`, then waits for the state change (or a timeout) before issuing the next one.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles needed before a synchronised button level is accepted (min 1).
- ACK_TIMEOUT, 32: cycles to wait in WAIT for `state` to change before abandoning the command (min 1).

Ports:
- clk  in  1: system clock.
- resetFSM  in  1: asynchronous, active-low reset.
- btn_start  in  1: raw start button, asynchronous, active-high.
- btn_pause  in  1: raw pause button, asynchronous, active-high.
- btn_reset  in  1: raw reset button, asynchronous, active-high.
- collision  in  1: synchronous, active-high death event from the game logic.
- state  in  3: `gameFSM` dataout. Encoding: 000 START, 001 PLAYING, 010 PAUSE, 011 RESET, 100 GAMEOVER.
- startGame  out  1: one-cycle command pulse to `gameFSM`.
- pauseGame  out  1: one-cycle command pulse to `gameFSM`.
- reset  out  1: one-cycle command pulse to `gameFSM` (game reset, not module reset).
- dead  out  1: one-cycle command pulse to `gameFSM`.
- busy  out  1: high while in ISSUE or WAIT.
- drop  out  1: one-cycle pulse when a pending command is discarded as illegal.
- timeout_err  out  1: sticky; set when a WAIT times out.

Behaviour:
- Reset: all outputs are 0, sequencer is in IDLE, pending flags clear. Synchronisers, debounced levels and counters are 0.
- Input path, per button:
  - 2-flop synchroniser.
  - Debounce counter increments while the synchronised level differs from the debounced level, and clears otherwise.
  - On reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Pending flags:
  - A 0→1 transition of a debounced level sets that button's pending flag on the next edge.
  - `collision`=1 sets pend_dead on the same edge; it is not debounced.
  - Flags are cleared only when issued or dropped.
  - A re-press while a flag is already set is absorbed.
- Priority when several flags are set: reset > dead > pause > start. Only the top flag is processed; the rest stay pending.
- Legality per command:
  - reset: legal in every state.
  - dead: legal only in PLAYING.
  - pause: legal only in PLAYING.
  - start: legal in START, RESET and PAUSE.
  - `state` values 101–111: only reset is legal.
- Sequencer FSM:
  - IDLE: if any flag is set, select the top-priority command and capture `state` as s0.
    - Legal: clear its flag and go to ISSUE.
    - Illegal: clear its flag, pulse `drop` one cycle, stay in IDLE.
  - ISSUE, one cycle: drive the selected command output high; clear the timeout counter; go to WAIT.
  - WAIT: if `state` != s0, go to IDLE. Otherwise increment the counter; when it reaches ACK_TIMEOUT, set `timeout_err` and go to IDLE.
  - At most one command output is high in any cycle. Command outputs are registered.
- Latency: with a clean press, the command output is high during the cycle after edge DEBOUNCE_CYCLES+4, counting from the first edge that samples the raw button high.
- Minimum spacing between two command pulses is 3 cycles (ISSUE, WAIT≥1, IDLE).
- A flag set during ISSUE or WAIT waits in pending. Priority is evaluated afresh on return to IDLE.
- Asserting `resetFSM` mid-operation returns everything to reset values immediately. A pulse in progress is cut.
- `timeout_err` clears only on `resetFSM`.

Optional Feature:
- Macro: PAUSE_TOGGLE_EN.
- Defined: a pause command in state PAUSE is legal and issues `startGame` (resume), i.e. the pause button toggles.
- Undefined: pause in PAUSE is illegal and is dropped with a `drop` pulse.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and ACK_TIMEOUT=8.
1. Reset then press: hold `resetFSM`=0 for 2 cycles, check all outputs 0. Release, `state`=011, hold `btn_start`=1 → `startGame` is a single-cycle pulse 8 cycles after the first sampled-high edge; `busy` goes high in the same cycle.
2. Bounce rejection: toggle `btn_pause` every 2 cycles for 20 cycles with `state`=001 → no `pauseGame` and no `drop`. Then hold it high for 10 cycles → exactly one `pauseGame` pulse.
3. Priority: `state`=001; drive `collision`=1 and raise `btn_pause`/`btn_reset` simultaneously, with the testbench model updating `state` after each pulse → `reset` first (state 011); pending dead is then dropped (`drop` pulse); then pause is dropped.
4. Illegal command: `state`=100, press `btn_pause` → `drop` pulses once, `pauseGame` stays 0, `busy` stays 0.
5. Timeout: `state` held at 001, press `btn_pause` → `pauseGame` pulse, `busy` high for 9 cycles, then `timeout_err`=1 and it stays 1 until `resetFSM`.
6. PAUSE_TOGGLE_EN: `state`=010, press `btn_pause`.
   - Macro defined → `startGame` pulse.
   - Macro undefined → `drop` pulse, no command output.
